// File: rtl/ls_pkg.sv
// ----------------------------------------------------------------------------
// ls_pkg
//  Shared types and helpers for the load/store queue (ls_queue) and its
//  lane-alignment datapath (ls_lane_align).
//   - ls_type_e  : op encoding coming from the dual-slot parse path
//   - ls_entry_t : one buffered queue entry {type, addr, wdata, tag}
//   - ls_state_e : issue FSM states
//   - is_store(), be_of(), is_misaligned(), align_offset()
//  The entry struct is sized by LS_XLEN / LS_TAG_W. ls_queue takes its XLEN
//  and TAG_W defaults from these, so change them here to resize the queue.
// ----------------------------------------------------------------------------
package ls_pkg;

    localparam int LS_XLEN  = 32;
    localparam int LS_TAG_W = 5;

    typedef enum logic [2:0] {
        LS_LW   = 3'b000,
        LS_LH   = 3'b001,
        LS_LB   = 3'b010,
        LS_SW   = 3'b100,
        LS_SH   = 3'b101,
        LS_SB   = 3'b110,
        LS_NONE = 3'b111
    } ls_type_e;

    typedef struct packed {
        ls_type_e             typ;
        logic [LS_XLEN-1:0]   addr;
        logic [LS_XLEN-1:0]   wdata;
        logic [LS_TAG_W-1:0]  tag;
    } ls_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R
    } ls_state_e;

    // Stores are the 1xx encodings, excluding the 111 "no op" code.
    function automatic logic is_store(input ls_type_e t);
        return t[2] && (t != LS_NONE);
    endfunction

    // Byte-enable mask for an access of type t at byte offset a.
    function automatic logic [3:0] be_of(input ls_type_e t, input logic [1:0] a);
        logic [3:0] be;
        case (t)
            LS_SB, LS_LB: be = 4'b0001 << a;
            LS_SH, LS_LH: be = a[1] ? 4'b1100 : 4'b0011;
            default:      be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input ls_type_e t, input logic [1:0] a);
        logic bad;
        case (t)
            LS_LW, LS_SW: bad = (a != 2'b00);
            LS_LH, LS_SH: bad = a[0];
            default:      bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Byte offset actually used on the bus: misaligned word/half accesses
    // are rounded down to their natural boundary.
    function automatic logic [1:0] align_offset(input ls_type_e t, input logic [1:0] a);
        logic [1:0] off;
        case (t)
            LS_LW, LS_SW: off = 2'b00;
            LS_LH, LS_SH: off = {a[1], 1'b0};
            default:      off = a;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/ls_lane_align.sv
// ----------------------------------------------------------------------------
// ls_lane_align
//  Combinational byte-lane datapath between the queue head and the 32-bit
//  single-port data memory.
//  Ports:
//   type_i     op type of the head entry
//   offset_i   byte offset within the word (already aligned for the op size)
//   st_data_i  raw store data, lsbs significant
//   ld_word_i  word returned by the memory
//   be_o       byte enables
//   st_data_o  store data replicated across all lanes
//   ld_data_o  selected load lane, sign-extended to XLEN
// ----------------------------------------------------------------------------
module ls_lane_align
    import ls_pkg::*;
#(
    parameter int XLEN = LS_XLEN
) (
    input  ls_type_e          type_i,
    input  logic [1:0]        offset_i,
    input  logic [XLEN-1:0]   st_data_i,
    input  logic [XLEN-1:0]   ld_word_i,
    output logic [3:0]        be_o,
    output logic [XLEN-1:0]   st_data_o,
    output logic [XLEN-1:0]   ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be_o    = be_of(type_i, offset_i);
        ld_byte = ld_word_i[{offset_i, 3'b000} +: 8];
        ld_half = offset_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

        // Replicating the narrow datum into every lane lets the memory pick
        // it up from whichever lane the byte enables select.
        case (type_i)
            LS_SB:   st_data_o = {4{st_data_i[7:0]}};
            LS_SH:   st_data_o = {2{st_data_i[15:0]}};
            default: st_data_o = st_data_i;
        endcase

        case (type_i)
            LS_LB:   ld_data_o = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            LS_LH:   ld_data_o = {{(XLEN-16){ld_half[15]}}, ld_half};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/ls_queue.sv
// ----------------------------------------------------------------------------
// ls_queue
//  Consumer end of the dual-slot load/store parse path. Buffers up to two ops
//  per cycle in a circular queue and issues them one at a time to a
//  single-port data memory (req/gnt + rvalid). Load results come back
//  sign-extended and tagged for writeback.
//  Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   ls_valid/type/addr/wdata/tag  slot 1 (older) and slot 2 (younger) ops
//   ls_ready_o                    at least two free entries
//   mem_req/we/addr/be/wdata_o    memory request, held until mem_gnt_i
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i  memory handshake and load data
//   ld_valid/tag/data_o           one-cycle load writeback pulse
//   err_valid/tag_o               one-cycle misaligned-drop pulse
//   count_o                       occupied entries
//  Configuration:
//   MISALIGN_TRAP_EN  defined   : misaligned head ops are dropped and
//                                 reported on err_valid_o / err_tag_o
//                     undefined : addresses are silently aligned down and
//                                 the err outputs are tied low
// ----------------------------------------------------------------------------
module ls_queue
    import ls_pkg::*;
#(
    parameter int XLEN  = LS_XLEN,
    parameter int DEPTH = 8,
    parameter int TAG_W = LS_TAG_W
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       ls_valid1_i,
    input  logic [2:0]                 ls_type1_i,
    input  logic [XLEN-1:0]            ls_addr1_i,
    input  logic [XLEN-1:0]            ls_wdata1_i,
    input  logic [TAG_W-1:0]           ls_tag1_i,
    input  logic                       ls_valid2_i,
    input  logic [2:0]                 ls_type2_i,
    input  logic [XLEN-1:0]            ls_addr2_i,
    input  logic [XLEN-1:0]            ls_wdata2_i,
    input  logic [TAG_W-1:0]           ls_tag2_i,
    output logic                       ls_ready_o,
    output logic                       mem_req_o,
    output logic                       mem_we_o,
    output logic [XLEN-1:0]            mem_addr_o,
    output logic [3:0]                 mem_be_o,
    output logic [XLEN-1:0]            mem_wdata_o,
    input  logic                       mem_gnt_i,
    input  logic                       mem_rvalid_i,
    input  logic [XLEN-1:0]            mem_rdata_i,
    output logic                       ld_valid_o,
    output logic [TAG_W-1:0]           ld_tag_o,
    output logic [XLEN-1:0]            ld_data_o,
    output logic                       err_valid_o,
    output logic [TAG_W-1:0]           err_tag_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    ls_entry_t        entries_q [DEPTH];
    ls_entry_t        entries_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    ls_state_e        state_q, state_d;
    logic             ld_valid_q, ld_valid_d;
    logic [TAG_W-1:0] ld_tag_q, ld_tag_d;
    logic [XLEN-1:0]  ld_data_q, ld_data_d;

    ls_entry_t        head;
    logic [1:0]       head_off;
    logic             head_bad;
    logic             ready;
    logic             push1, push2, pop;
    logic [3:0]       lane_be;
    logic [XLEN-1:0]  lane_wdata;
    logic [XLEN-1:0]  lane_ld;

    assign head     = entries_q[rd_ptr_q];
    assign head_off = align_offset(head.typ, head.addr[1:0]);
    // Ready looks only at the registered count so it never depends on a pop
    // happening in the same cycle.
    assign ready    = (count_q <= CW'(DEPTH - 2));

`ifdef MISALIGN_TRAP_EN
    logic             err_valid_q, err_valid_d;
    logic [TAG_W-1:0] err_tag_q, err_tag_d;
    assign head_bad    = is_misaligned(head.typ, head.addr[1:0]);
    assign err_valid_o = err_valid_q;
    assign err_tag_o   = err_tag_q;
`else
    assign head_bad    = 1'b0;
    assign err_valid_o = 1'b0;
    assign err_tag_o   = '0;
`endif

    ls_lane_align #(
        .XLEN      (XLEN)
    ) u_lane_align (
        .type_i    (head.typ),
        .offset_i  (head_off),
        .st_data_i (head.wdata),
        .ld_word_i (mem_rdata_i),
        .be_o      (lane_be),
        .st_data_o (lane_wdata),
        .ld_data_o (lane_ld)
    );

    // Enqueue: slot 1 goes first, and whichever ops are valid pack into
    // consecutive entries starting at the write pointer.
    always_comb begin
        push1     = ready && ls_valid1_i && (ls_type1_i != LS_NONE);
        push2     = ready && ls_valid2_i && (ls_type2_i != LS_NONE);
        entries_d = entries_q;
        if (push1) begin
            entries_d[wr_ptr_q] = '{typ: ls_type_e'(ls_type1_i), addr: ls_addr1_i,
                                    wdata: ls_wdata1_i, tag: ls_tag1_i};
        end
        if (push2) begin
            entries_d[wr_ptr_q + PW'(push1)] = '{typ: ls_type_e'(ls_type2_i), addr: ls_addr2_i,
                                                 wdata: ls_wdata2_i, tag: ls_tag2_i};
        end
        wr_ptr_d = wr_ptr_q + PW'(push1) + PW'(push2);
    end

    // Issue FSM: one memory op in flight; stores retire on grant, loads on
    // the returning rvalid.
    always_comb begin
        pop        = 1'b0;
        state_d    = state_q;
        ld_valid_d = 1'b0;
        ld_tag_d   = '0;
        ld_data_d  = '0;
`ifdef MISALIGN_TRAP_EN
        err_valid_d = 1'b0;
        err_tag_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if ((count_q != '0) || push1 || push2) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (head_bad) begin
                    pop = 1'b1;
`ifdef MISALIGN_TRAP_EN
                    err_valid_d = 1'b1;
                    err_tag_d   = head.tag;
`endif
                end else if (mem_gnt_i) begin
                    if (is_store(head.typ)) begin
                        pop = 1'b1;
                    end else begin
                        state_d = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                if (mem_rvalid_i) begin
                    pop        = 1'b1;
                    ld_valid_d = 1'b1;
                    ld_tag_d   = head.tag;
                    ld_data_d  = lane_ld;
                end
            end
            default: state_d = IDLE;
        endcase
        count_d  = count_q + CW'(push1) + CW'(push2) - CW'(pop);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        if (pop) begin
            state_d = (count_d != '0) ? REQ : IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            ld_valid_q <= 1'b0;
            ld_tag_q   <= '0;
            ld_data_q  <= '0;
`ifdef MISALIGN_TRAP_EN
            err_valid_q <= 1'b0;
            err_tag_q   <= '0;
`endif
        end else begin
            entries_q  <= entries_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            ld_valid_q <= ld_valid_d;
            ld_tag_q   <= ld_tag_d;
            ld_data_q  <= ld_data_d;
`ifdef MISALIGN_TRAP_EN
            err_valid_q <= err_valid_d;
            err_tag_q   <= err_tag_d;
`endif
        end
    end

    // Request fields come straight from the head entry, so they stay stable
    // for as long as the request waits for a grant; they read 0 otherwise.
    assign mem_req_o   = (state_q == REQ) && !head_bad;
    assign mem_we_o    = mem_req_o && is_store(head.typ);
    assign mem_addr_o  = mem_req_o ? {head.addr[XLEN-1:2], 2'b00} : '0;
    assign mem_be_o    = mem_req_o ? lane_be : 4'b0000;
    assign mem_wdata_o = mem_req_o ? lane_wdata : '0;

    assign ls_ready_o  = ready;
    assign ld_valid_o  = ld_valid_q;
    assign ld_tag_o    = ld_tag_q;
    assign ld_data_o   = ld_data_q;
    assign count_o     = count_q;

endmodule
